// File: rtl/mdu_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
// mdu_op codes, FSM states, divider iteration count, op-class helpers.
// Optional MDU_MACC_EN enables MADD/MADDU/MSUB/MSUBU.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  localparam int DIV_ITERS = 32;

  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MACC_EN
    return op inside {MDU_MULT, MDU_MULTU,
                      MDU_MADD, MDU_MADDU,
                      MDU_MSUB, MDU_MSUBU};
`else
    return op inside {MDU_MULT, MDU_MULTU};
`endif
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op inside {MDU_DIV, MDU_DIVU};
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_DIV,
                      MDU_MADD, MDU_MSUB};
  endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// EX-stage <-> MDU bundle: issue/operands in, stall and HI/LO write out.
// slave = MDU side, master = pipeline side.
interface ex_mdu_if;
  logic        flush_i;
  logic        start_i;
  logic [3:0]  op_i;
  logic [31:0] srca_i;
  logic [31:0] srcb_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        busy_o;
  logic        we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport slave (
    input  flush_i, start_i, op_i,
    input  srca_i, srcb_i, hi_i, lo_i,
    output busy_o, we_o, hi_o, lo_o
  );

  modport master (
    output flush_i, start_i, op_i,
    output srca_i, srcb_i, hi_i, lo_i,
    input  busy_o, we_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_mdu_div_core.sv
// Unsigned radix-2 restoring divider, one quotient bit per step.
// Ports: clk, rst, load_i/step_i, dividend_i, divisor_i -> quot_o, rem_o.
module div_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  // {remainder, dividend/quotient}; quotient bits shift in at the bottom
  logic [63:0] rq_q, rq_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] trial;
  logic [32:0] diff;

  always_comb begin
    rq_d  = rq_q;
    dvs_d = dvs_q;
    trial = rq_q[63:31];
    diff  = trial - {1'b0, dvs_q};
    if (load_i) begin
      rq_d  = {32'd0, dividend_i};
      dvs_d = divisor_i;
    end else if (step_i) begin
      if (!diff[32]) begin
        rq_d = {diff[31:0], rq_q[30:0], 1'b1};
      end else begin
        rq_d = {trial[31:0], rq_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rq_q  <= '0;
      dvs_q <= '0;
    end else begin
      rq_q  <= rq_d;
      dvs_q <= dvs_d;
    end
  end

  assign quot_o = rq_q[31:0];
  assign rem_o  = rq_q[63:32];

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: MULT/DIV/MTHI/MTLO, busy stall, HI/LO we.
// Ports: clk, rst (sync, high), mdu (ex_mdu_if.slave). Macro MDU_MACC_EN.
module ex_mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  ex_mdu_if.slave     mdu
);

  mdu_state_e  state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] prod_q, prod_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
`ifdef MDU_MACC_EN
  logic [63:0] acc_q, acc_d;
`endif

  logic        busy;
  logic        we;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        go;
  logic        start_mul;
  logic        start_div;
  logic        mt_hi;
  logic        mt_lo;
  logic        sa;
  logic        sb;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        div_step;
  logic [31:0] quot;
  logic [31:0] rem;

  logic               msgn;
  logic signed [65:0] ma;
  logic signed [65:0] mb;
  logic signed [65:0] mfull;
  logic [63:0]        mres;

  assign go = (state_q == S_IDLE)
            && mdu.start_i && !mdu.flush_i;
  assign start_mul = go && is_mul_op(mdu.op_i);
  assign start_div = go && is_div_op(mdu.op_i);
  assign mt_hi = go && (mdu.op_i == MDU_MTHI);
  assign mt_lo = go && (mdu.op_i == MDU_MTLO);

  assign sa = mdu.srca_i[31] && is_signed_op(mdu.op_i);
  assign sb = mdu.srcb_i[31] && is_signed_op(mdu.op_i);
  assign a_abs = sa ? -mdu.srca_i : mdu.srca_i;
  assign b_abs = sb ? -mdu.srcb_i : mdu.srcb_i;

  assign div_step = (state_q == S_DIV) && !mdu.flush_i;

  div_core u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (start_div),
    .step_i     (div_step),
    .dividend_i (a_abs),
    .divisor_i  (b_abs),
    .quot_o     (quot),
    .rem_o      (rem)
  );

  // 33-bit operands give one multiplier for signed and unsigned
  assign msgn  = is_signed_op(op_q);
  assign ma    = {{34{msgn & a_q[31]}}, a_q};
  assign mb    = {{34{msgn & b_q[31]}}, b_q};
  assign mfull = ma * mb;

  always_comb begin
    mres = prod_q;
`ifdef MDU_MACC_EN
    if (op_q inside {MDU_MADD, MDU_MADDU}) begin
      mres = acc_q + prod_q;
    end else if (op_q inside {MDU_MSUB, MDU_MSUBU}) begin
      mres = acc_q - prod_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`ifdef MDU_MACC_EN
    acc_d   = acc_q;
`endif
    busy    = 1'b0;
    we      = 1'b0;
    hi_r    = '0;
    lo_r    = '0;

    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          start_mul: begin
            busy    = 1'b1;
            op_d    = mdu.op_i;
            a_d     = mdu.srca_i;
            b_d     = mdu.srcb_i;
`ifdef MDU_MACC_EN
            acc_d   = {mdu.hi_i, mdu.lo_i};
`endif
            state_d = S_MUL;
          end
          start_div: begin
            busy    = 1'b1;
            op_d    = mdu.op_i;
            a_d     = mdu.srca_i;
            b_d     = mdu.srcb_i;
            qneg_d  = sa ^ sb;
            rneg_d  = sa;
            cnt_d   = '0;
            state_d = S_DIV;
          end
          mt_hi: begin
            we   = 1'b1;
            hi_r = mdu.srca_i;
            lo_r = mdu.lo_i;
          end
          mt_lo: begin
            we   = 1'b1;
            hi_r = mdu.hi_i;
            lo_r = mdu.srca_i;
          end
          default: ;
        endcase
      end
      S_MUL: begin
        busy    = 1'b1;
        prod_d  = mfull[63:0];
        state_d = S_DONE;
      end
      S_DIV: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_ITERS - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        we      = 1'b1;
        state_d = S_IDLE;
        if (is_div_op(op_q)) begin
          // divide-by-zero reports the raw dividend in HI
          if (b_q == '0) begin
            lo_r = '1;
            hi_r = a_q;
          end else begin
            lo_r = qneg_q ? -quot : quot;
            hi_r = rneg_q ? -rem : rem;
          end
        end else begin
          hi_r = mres[63:32];
          lo_r = mres[31:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (mdu.flush_i) begin
      busy    = 1'b0;
      we      = 1'b0;
      hi_r    = '0;
      lo_r    = '0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`ifdef MDU_MACC_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`ifdef MDU_MACC_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign mdu.busy_o = busy;
  assign mdu.we_o   = we;
  assign mdu.hi_o   = hi_r;
  assign mdu.lo_o   = lo_r;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed-vector bench for ex_mdu: latency, results, flush/reset abort.
// Covers both MDU_MACC_EN builds.
module tb_ex_mdu;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_mdu_if bus();

  ex_mdu dut (
    .clk (clk),
    .rst (rst),
    .mdu (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic st, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l);
    rst         = 1'b0;
    bus.flush_i = 1'b0;
    bus.start_i = st;
    bus.op_i    = op;
    bus.srca_i  = a;
    bus.srcb_i  = b;
    bus.hi_i    = h;
    bus.lo_i    = l;
  endtask

  // Issue op and hold start_i until we_o (or 40 cycles); cycle 1 = issue
  task automatic run_op(input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h, input logic [31:0] l,
                        output int nb, output int wc,
                        output logic [31:0] ho, output logic [31:0] lo);
    nb = 0;
    wc = 0;
    ho = '0;
    lo = '0;
    @(negedge clk);
    drive(1'b1, op, a, b, h, l);
    #1;
    for (int c = 1; c <= 40; c++) begin
      if (bus.busy_o) nb++;
      if (bus.we_o) begin
        wc = c;
        ho = bus.hi_o;
        lo = bus.lo_o;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic idle(output logic we_seen);
    @(negedge clk);
    drive(1'b0, MDU_NOP, '0, '0, '0, '0);
    #1;
    we_seen = bus.we_o;
  endtask

  task automatic test_reset();
    drive(1'b0, MDU_NOP, '0, '0, '0, '0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", bus.busy_o);
    end
    checks++;
    if (bus.we_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_we got %b want 0", bus.we_o);
    end
    checks++;
    if (bus.hi_o !== 32'd0 || bus.lo_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo got %h/%h want 0/0",
               bus.hi_o, bus.lo_o);
    end
  endtask

  task automatic test_mult();
    int nb, wc;
    logic [31:0] h, l;
    logic ws;
    run_op(MDU_MULT, 32'hFFFFFFFE, 32'd3, 0, 0, nb, wc, h, l);
    checks++;
    if (nb !== 2 || wc !== 3) begin
      errors++;
      $display("FAIL mult_lat busy %0d we@%0d want 2 3", nb, wc);
    end
    checks++;
    if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL mult_val got %h/%h want ffffffff/fffffffa", h, l);
    end
    idle(ws);
    checks++;
    if (ws !== 1'b0) begin
      errors++;
      $display("FAIL mult_we_pulse got %b want 0", ws);
    end
    run_op(MDU_MULTU, 32'hFFFFFFFE, 32'd3, 0, 0, nb, wc, h, l);
    checks++;
    if (nb !== 2 || wc !== 3) begin
      errors++;
      $display("FAIL multu_lat busy %0d we@%0d want 2 3", nb, wc);
    end
    checks++;
    if (h !== 32'h2 || l !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL multu_val got %h/%h want 2/fffffffa", h, l);
    end
    idle(ws);
  endtask

  task automatic test_div();
    int nb, wc;
    logic [31:0] h, l;
    logic ws;
    run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, nb, wc, h, l);
    checks++;
    if (nb !== 33 || wc !== 34) begin
      errors++;
      $display("FAIL div_lat busy %0d we@%0d want 33 34", nb, wc);
    end
    checks++;
    if (l !== 32'hFFFFFFFD || h !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL div_neg got lo %h hi %h want fffffffd ffffffff", l, h);
    end
    idle(ws);
    checks++;
    if (ws !== 1'b0) begin
      errors++;
      $display("FAIL div_we_pulse got %b want 0", ws);
    end
    run_op(MDU_DIVU, 32'd7, 32'd2, 0, 0, nb, wc, h, l);
    checks++;
    if (l !== 32'd3 || h !== 32'd1 || wc !== 34) begin
      errors++;
      $display("FAIL divu got lo %h hi %h we@%0d want 3 1 34", l, h, wc);
    end
    idle(ws);
    run_op(MDU_DIV, 32'd7, 32'hFFFFFFFE, 0, 0, nb, wc, h, l);
    checks++;
    if (l !== 32'hFFFFFFFD || h !== 32'd1) begin
      errors++;
      $display("FAIL div_negb got lo %h hi %h want fffffffd 1", l, h);
    end
    idle(ws);
  endtask

  task automatic test_div_edge();
    int nb, wc;
    logic [31:0] h, l;
    logic ws;
    run_op(MDU_DIVU, 32'd5, 32'd0, 0, 0, nb, wc, h, l);
    checks++;
    if (l !== 32'hFFFFFFFF || h !== 32'd5 || wc !== 34) begin
      errors++;
      $display("FAIL divu_zero got lo %h hi %h we@%0d want ffffffff 5 34",
               l, h, wc);
    end
    idle(ws);
    run_op(MDU_DIV, 32'hFFFFFFFB, 32'd0, 0, 0, nb, wc, h, l);
    checks++;
    if (l !== 32'hFFFFFFFF || h !== 32'hFFFFFFFB || nb !== 33) begin
      errors++;
      $display("FAIL div_zero got lo %h hi %h busy %0d want ffffffff fffffffb 33",
               l, h, nb);
    end
    idle(ws);
    run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, nb, wc, h, l);
    checks++;
    if (l !== 32'h80000000 || h !== 32'd0) begin
      errors++;
      $display("FAIL div_ovf got lo %h hi %h want 80000000 0", l, h);
    end
    idle(ws);
  endtask

  task automatic test_mt();
    int nb, wc;
    logic [31:0] h, l;
    logic ws;
    run_op(MDU_MTHI, 32'h1234, 0, 32'h99, 32'h55, nb, wc, h, l);
    checks++;
    if (nb !== 0 || wc !== 1) begin
      errors++;
      $display("FAIL mthi_lat busy %0d we@%0d want 0 1", nb, wc);
    end
    checks++;
    if (h !== 32'h1234 || l !== 32'h55) begin
      errors++;
      $display("FAIL mthi_val got %h/%h want 1234/55", h, l);
    end
    run_op(MDU_MTLO, 32'hABCD, 0, 32'h77, 32'h66, nb, wc, h, l);
    checks++;
    if (nb !== 0 || wc !== 1 || h !== 32'h77 || l !== 32'hABCD) begin
      errors++;
      $display("FAIL mtlo got busy %0d we@%0d %h/%h want 0 1 77/abcd",
               nb, wc, h, l);
    end
    idle(ws);
  endtask

  task automatic test_unknown();
    int nb, wc;
    logic [31:0] h, l;
    logic ws;
    run_op(MDU_NOP, 32'd1, 32'd1, 0, 0, nb, wc, h, l);
    checks++;
    if (nb !== 0 || wc !== 0) begin
      errors++;
      $display("FAIL nop got busy %0d we@%0d want 0 0", nb, wc);
    end
    run_op(4'd11, 32'd1, 32'd1, 0, 0, nb, wc, h, l);
    checks++;
    if (nb !== 0 || wc !== 0) begin
      errors++;
      $display("FAIL op11 got busy %0d we@%0d want 0 0", nb, wc);
    end
    idle(ws);
  endtask

  task automatic test_macc();
    int nb, wc;
    logic [31:0] h, l;
    logic ws;
    run_op(MDU_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, nb, wc, h, l);
`ifdef MDU_MACC_EN
    checks++;
    if (nb !== 2 || wc !== 3 || h !== 32'd1 || l !== 32'd0) begin
      errors++;
      $display("FAIL maddu got busy %0d we@%0d %h/%h want 2 3 1/0",
               nb, wc, h, l);
    end
    idle(ws);
    run_op(MDU_MSUB, 32'd2, 32'd3, 32'd0, 32'd0, nb, wc, h, l);
    checks++;
    if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL msub got %h/%h want ffffffff/fffffffa", h, l);
    end
`else
    checks++;
    if (nb !== 0 || wc !== 0) begin
      errors++;
      $display("FAIL maddu_off got busy %0d we@%0d want 0 0", nb, wc);
    end
`endif
    idle(ws);
  endtask

  // abort a DIV in its 10th iteration cycle, by flush or by reset
  task automatic test_abort(input logic use_rst);
    int nb, wc, late;
    logic early;
    logic [31:0] h, l;
    logic ws;
    early = 1'b0;
    late  = 0;
    @(negedge clk);
    drive(1'b1, MDU_DIV, 32'hFFFFFFF9, 32'd2, 0, 0);
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (bus.we_o) early = 1'b1;
      @(negedge clk);
    end
    if (use_rst) rst = 1'b1;
    else bus.flush_i = 1'b1;
    #1;
    checks++;
    if (bus.we_o !== 1'b0 || early !== 1'b0) begin
      errors++;
      $display("FAIL abort_we rst=%b got %b/%b want 0/0",
               use_rst, bus.we_o, early);
    end
    if (!use_rst) begin
      checks++;
      if (bus.busy_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_busy got %b want 0", bus.busy_o);
      end
    end
    run_op(MDU_MULT, 32'hFFFFFFFE, 32'd3, 0, 0, nb, wc, h, l);
    checks++;
    if (wc !== 3 || h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL abort_mult rst=%b we@%0d %h/%h want 3 ffffffff/fffffffa",
               use_rst, wc, h, l);
    end
    for (int c = 0; c < 40; c++) begin
      idle(ws);
      if (ws) late++;
    end
    checks++;
    if (late !== 0) begin
      errors++;
      $display("FAIL abort_late rst=%b got %0d we pulses want 0",
               use_rst, late);
    end
  endtask

  task automatic test_back_to_back();
    int nb, wc;
    logic [31:0] h, l;
    logic ws;
    run_op(MDU_MULTU, 32'd6, 32'd7, 0, 0, nb, wc, h, l);
    checks++;
    if (h !== 32'd0 || l !== 32'd42) begin
      errors++;
      $display("FAIL b2b_mul got %h/%h want 0/2a", h, l);
    end
    run_op(MDU_DIVU, 32'd100, 32'd7, 0, 0, nb, wc, h, l);
    checks++;
    if (wc !== 34 || l !== 32'd14 || h !== 32'd2) begin
      errors++;
      $display("FAIL b2b_div we@%0d lo %h hi %h want 34 e 2", wc, l, h);
    end
    run_op(MDU_MTLO, 32'h5A, 0, 32'h3C, 0, nb, wc, h, l);
    checks++;
    if (wc !== 1 || h !== 32'h3C || l !== 32'h5A) begin
      errors++;
      $display("FAIL b2b_mt we@%0d %h/%h want 1 3c/5a", wc, h, l);
    end
    idle(ws);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_edge();
    test_mt();
    test_unknown();
    test_macc();
    test_abort(1'b0);
    test_abort(1'b1);
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
# ex_mdu

Execute-stage multiply/divide unit for the 5-stage MIPS pipeline. It takes the operands latched by the ID/EX register and performs MULT/MULTU, DIV/DIVU and MTHI/MTLO, plus the optional accumulate ops. It drives a busy stall request to the hazard unit, which holds the ID/EX register (stallE) and the upstream stages. It presents HI/LO results with a one-cycle write enable for the EX/MEM register.

## Interface
- No parameters; latencies are fixed (below).
- clk  in  1  clock
- rst  in  1  reset; rst, synchronous, active-high; clock clk
- flush_i  in  1  EX flush (exception/branch kill); aborts any operation
- start_i  in  1  valid MDU instruction present in EX this cycle
- op_i  in  4  mdu_op code from mdu_pkg
- srca_i  in  32  rs operand (forwarded)
- srcb_i  in  32  rt operand (forwarded)
- hi_i  in  32  current HI (forwarded); used by MTLO and accumulate ops
- lo_i  in  32  current LO (forwarded); used by MTHI and accumulate ops
- busy_o  out  1  stall request; OR'd into stallE/stallD/stallF
- we_o  out  1  HI/LO write enable, one-cycle pulse
- hi_o  out  32  HI result, valid when we_o=1
- lo_o  out  32  LO result, valid when we_o=1

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Reset → IDLE, with we_o=0, busy_o=0, and hi_o/lo_o and all internal registers at 0.
- IDLE, start_i with MTHI: we_o=1 combinationally the same cycle, hi_o=srca_i, lo_o=lo_i, no busy. MTLO: hi_o=hi_i, lo_o=srca_i.
- IDLE, start_i with MULT/MULTU (and MADD*/MSUB* when enabled):
  - busy_o=1 combinationally.
  - Latch operands, op, hi_i and lo_i, then go to MUL.
- MUL: register the 64-bit product (signed for MULT/MADD/MSUB, else unsigned), busy_o=1, then go to DONE.
- IDLE, start_i with DIV/DIVU: busy_o=1.
  - Latch the absolute values (DIV) or raw values (DIVU), the quotient sign (sa^sb) and the remainder sign (sa).
  - Clear the 5-bit counter, then go to DIV.
- DIV: one restoring iteration per cycle, busy_o=1. After the iteration with count==31, go to DONE.
- DONE: busy_o=0, we_o=1, and the outputs carry the sign-corrected or accumulated result. Always go to IDLE.
  - start_i is still high in DONE because the instruction has not yet left EX. It must not retrigger.
- Division results:
  - lo_o = quotient, hi_o = remainder.
  - Remainder takes the dividend's sign.
  - Divide-by-zero: lo_o=32'hFFFFFFFF, hi_o=srca (raw dividend). Full latency still applies.
  - DIV 32'h80000000 / 32'hFFFFFFFF gives lo_o=32'h80000000, hi_o=0.
- Unknown op, or start_i=0: no busy and no we_o.
- flush_i=1 in any state: busy_o forced 0 and we_o forced 0 that cycle, next state IDLE, the operation is discarded. flush_i has priority over start_i.
- rst mid-operation: next state IDLE, no we_o pulse.
- A start_i in IDLE while flush_i=1 is ignored.

## Timing
- MTHI/MTLO: 0 stall cycles, we_o in the issue cycle.
- MULT family: issue cycle and MUL are busy (2 stall cycles); we_o in cycle 3.
- DIV family: issue cycle plus 32 DIV cycles are busy (33 stall cycles); we_o in cycle 34.
- busy_o is purely a function of state, start_i, op_i and flush_i. It has no register delay, so the stall takes effect in the issue cycle.
- we_o, hi_o and lo_o are stable for exactly one cycle. In the cycle after DONE the stall is released and the instruction advances.

## Configuration
- MDU_MACC_EN defined: MADD/MADDU/MSUB/MSUBU are supported.
  - Result in DONE = {hi,lo latched at issue} ± the 64-bit product, computed modulo 2^64.
  - Same latency as MULT.
- MDU_MACC_EN undefined: these op codes behave as unknown ops (no busy, no we_o). The accumulate adder is not synthesised.

## Structure
- mdu_pkg holds the mdu_op encodings:
  - MDU_NOP=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6.
  - MDU_MADD=7, MDU_MADDU=8, MDU_MSUB=9, MDU_MSUBU=10.
  - It also holds the FSM state encoding and the DIV_ITERS=32 constant.
- Sub-module div_core: an unsigned radix-2 restoring divider datapath. It has a load/step interface with 64-bit remainder:quotient shift register and is sequenced by the ex_mdu FSM.

## Test plan
- MULT srca=32'hFFFFFFFE (-2), srcb=3 → busy for 2 cycles, then we_o with hi_o=32'hFFFFFFFF, lo_o=32'hFFFFFFFA. MULTU with the same operands gives hi_o=2, lo_o=32'hFFFFFFFA.
- DIV -7/2 → busy for 33 cycles, we_o in cycle 34 with lo_o=32'hFFFFFFFD, hi_o=32'hFFFFFFFF. DIVU 7/2 gives lo_o=3, hi_o=1.
- DIVU 5/0 → lo_o=32'hFFFFFFFF, hi_o=5 after full latency. DIV 32'h80000000/-1 gives lo_o=32'h80000000, hi_o=0.
- MTHI srca=32'h1234, lo_i=32'h55 → we_o in the same cycle, hi_o=32'h1234, lo_o=32'h55, busy_o never high.
- Start DIV, assert flush_i in DIV cycle 10 → busy_o=0 immediately, no we_o ever. A MULT issued next cycle completes normally. Repeat with rst instead of flush_i.
- With MDU_MACC_EN: hi_i=0, lo_i=32'hFFFFFFFF, MADDU 1×1 → hi_o=1, lo_o=0. Without the macro, the same op gives no busy and no we_o.
